// File: rtl/step_pulse_driver_if.sv
// Host-facing bundle of the step pulse driver: move/load requests in,
// step pulses and model status out.
interface step_pulse_driver_if #(
  parameter int WIDTH = 16
);
  logic             load;
  logic             start;
  logic [WIDTH-1:0] preload;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] increment;
  logic             step_up;
  logic             step_dn;
  logic             step_rst;
  logic [WIDTH-1:0] model_count;
  logic             busy;
  logic             done;
  logic             inexact;

  modport master (
    output load, start, preload, target, increment,
    input  step_up, step_dn, step_rst, model_count, busy, done, inexact
  );

  modport slave (
    input  load, start, preload, target, increment,
    output step_up, step_dn, step_rst, model_count, busy, done, inexact
  );
endinterface

// File: rtl/step_pulse_driver.sv
// Drives spaced up/down/reset pulses into a downstream preloadable counter so
// that it walks from its modelled value to an absolute target.
module step_pulse_driver #(
  parameter int WIDTH     = 16,
  parameter int PULSE_LEN = 2,
  parameter int GAP_LEN   = 3
) (
  input logic                clk_2M5,
  input logic                reset,
  step_pulse_driver_if.slave bus
);

  localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE, DECIDE, PULSE, GAP} state_e;
  typedef enum logic [1:0] {KIND_UP, KIND_DN, KIND_RST} kind_e;

  state_e           state;
  kind_e            kind;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] incr_q;

  logic [WIDTH-1:0] up_dist;
  logic [WIDTH-1:0] dn_dist;
  logic             up_ok;
  logic             dn_ok;

  // Distances are taken only in the direction that cannot underflow, so a
  // step that passes the check can never wrap the model.
  always_comb begin
    up_dist = target_q - bus.model_count;
    dn_dist = bus.model_count - target_q;
    up_ok   = (target_q > bus.model_count) && (incr_q != '0) && (up_dist >= incr_q);
    dn_ok   = (target_q < bus.model_count) && (incr_q != '0) && (dn_dist >= incr_q);
  end

  // NOTE: every register here, outputs included, is updated with non-blocking
  // assignments in this one block so all outputs change together on the edge.
  always_ff @(posedge clk_2M5 or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      kind            <= KIND_UP;
      cnt             <= '0;
      target_q        <= '0;
      incr_q          <= '0;
      bus.step_up     <= 1'b0;
      bus.step_dn     <= 1'b0;
      bus.step_rst    <= 1'b0;
      bus.model_count <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.inexact     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.load) begin
            kind            <= KIND_RST;
            bus.step_rst    <= 1'b1;
            bus.model_count <= bus.preload;
            cnt             <= CNT_W'(PULSE_LEN - 1);
            bus.busy        <= 1'b1;
            state           <= PULSE;
          end else if (bus.start) begin
            target_q    <= bus.target;
            incr_q      <= bus.increment;
            bus.inexact <= 1'b0;
            bus.busy    <= 1'b1;
            state       <= DECIDE;
          end
        end

        DECIDE: begin
          if (up_ok) begin
            kind            <= KIND_UP;
            bus.step_up     <= 1'b1;
            bus.model_count <= bus.model_count + incr_q;
            cnt             <= CNT_W'(PULSE_LEN - 1);
            state           <= PULSE;
          end else if (dn_ok) begin
            kind            <= KIND_DN;
            bus.step_dn     <= 1'b1;
            bus.model_count <= bus.model_count - incr_q;
            cnt             <= CNT_W'(PULSE_LEN - 1);
            state           <= PULSE;
          end else begin
            // Either on target, or the remaining distance is smaller than one step.
            if (bus.model_count != target_q) bus.inexact <= 1'b1;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end

        PULSE: begin
          if (cnt == '0) begin
            bus.step_up  <= 1'b0;
            bus.step_dn  <= 1'b0;
            bus.step_rst <= 1'b0;
            cnt          <= CNT_W'(GAP_LEN - 1);
            state        <= GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        GAP: begin
          // A load reports completion during the final gap cycle.
          if (kind == KIND_RST && cnt == CNT_W'(1)) bus.done <= 1'b1;
          if (cnt == '0) begin
            if (kind == KIND_RST) begin
              bus.busy <= 1'b0;
              state    <= IDLE;
            end else begin
              state <= DECIDE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_step_pulse_driver.sv
// Scoreboard bench for step_pulse_driver: stimulus queues the expected pulse
// and done events, a negedge monitor pops and compares them as they appear.
`timescale 1ns/1ps
module tb_step_pulse_driver;

  localparam int WIDTH     = 16;
  localparam int PULSE_LEN = 2;
  localparam int GAP_LEN   = 3;

  logic clk_2M5 = 1'b0;
  logic reset   = 1'b0;
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   busy_cycles = 0;

  step_pulse_driver_if #(.WIDTH(WIDTH)) bus ();

  step_pulse_driver #(
    .WIDTH    (WIDTH),
    .PULSE_LEN(PULSE_LEN),
    .GAP_LEN  (GAP_LEN)
  ) dut (
    .clk_2M5(clk_2M5),
    .reset  (reset),
    .bus    (bus)
  );

  always #200 clk_2M5 = ~clk_2M5;
  always @(posedge clk_2M5) cyc <= cyc + 1;

  typedef enum {EV_UP, EV_DN, EV_RST, EV_DONE} ev_kind_e;
  typedef struct {
    ev_kind_e         kind;
    int               cyc;
    logic [WIDTH-1:0] model;
    logic             inexact;
    logic             busy;
  } ev_t;

  ev_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input ev_kind_e k, input int c, input logic [WIDTH-1:0] m,
                           input logic x, input logic b);
    ev_t e;
    e.kind = k; e.cyc = c; e.model = m; e.inexact = x; e.busy = b;
    exp_q.push_back(e);
  endtask

  task automatic got_event(input ev_kind_e k);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event: got %s at cycle %0d, expected none", k.name(), cyc);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("%s_kind", e.kind.name()), k, e.kind);
      check($sformatf("%s_cycle", e.kind.name()), cyc, e.cyc);
      check($sformatf("%s_model", e.kind.name()), bus.model_count, e.model);
      check($sformatf("%s_inexact", e.kind.name()), bus.inexact, e.inexact);
      check($sformatf("%s_busy", e.kind.name()), bus.busy, e.busy);
    end
  endtask

  // Monitor: rising edges of each step output and every done cycle are events.
  logic up_d, dn_d, rst_d;
  int   width;
  always @(negedge clk_2M5) begin
    if (!reset) begin
      up_d = 1'b0; dn_d = 1'b0; rst_d = 1'b0; width = 0;
    end else begin
      check("onehot_steps", ($countones({bus.step_up, bus.step_dn, bus.step_rst}) <= 1), 1);
      if (bus.step_up  && !up_d)  got_event(EV_UP);
      if (bus.step_dn  && !dn_d)  got_event(EV_DN);
      if (bus.step_rst && !rst_d) got_event(EV_RST);
      if (bus.done)               got_event(EV_DONE);
      if (bus.step_up || bus.step_dn || bus.step_rst) width++;
      else if (width != 0) begin
        check("pulse_width", width, PULSE_LEN);
        width = 0;
      end
      if (bus.busy) busy_cycles++;
      up_d = bus.step_up; dn_d = bus.step_dn; rst_d = bus.step_rst;
    end
  end

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk_2M5);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d events still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk_2M5);
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_step_up"},  bus.step_up,     0);
    check({tag, "_step_dn"},  bus.step_dn,     0);
    check({tag, "_step_rst"}, bus.step_rst,    0);
    check({tag, "_model"},    bus.model_count, 0);
    check({tag, "_busy"},     bus.busy,        0);
    check({tag, "_done"},     bus.done,        0);
    check({tag, "_inexact"},  bus.inexact,     0);
  endtask

  initial begin
    #(400 * 5000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int n;
    bus.load = 1'b0; bus.start = 1'b0;
    bus.preload = '0; bus.target = '0; bus.increment = '0;

    repeat (3) @(negedge clk_2M5);
    check_all_low("reset");
    reset = 1'b1;
    @(negedge clk_2M5);

    // Load preload=5: 2-cycle reset pulse, 3-cycle gap, done in last gap cycle.
    busy_cycles = 0;
    c = cyc;
    bus.load = 1'b1; bus.preload = 16'd5;
    expect_ev(EV_RST,  c + 1, 16'd5, 1'b0, 1'b1);
    expect_ev(EV_DONE, c + 5, 16'd5, 1'b0, 1'b1);
    @(negedge clk_2M5);
    bus.load = 1'b0;
    drain(20);
    check("load_busy_cycles", busy_cycles, 5);

    // 5 -> 11 by 2: three up pulses spaced 6 cycles.
    busy_cycles = 0;
    c = cyc;
    bus.start = 1'b1; bus.target = 16'd11; bus.increment = 16'd2;
    expect_ev(EV_UP,   c + 2,  16'd7,  1'b0, 1'b1);
    expect_ev(EV_UP,   c + 8,  16'd9,  1'b0, 1'b1);
    expect_ev(EV_UP,   c + 14, 16'd11, 1'b0, 1'b1);
    expect_ev(EV_DONE, c + 20, 16'd11, 1'b0, 1'b0);
    @(negedge clk_2M5);
    bus.start = 1'b0;
    drain(40);
    check("move_up_busy_cycles", busy_cycles, 19);

    // 11 -> 4 by 3: two down pulses to 5, then the remainder of 1 is inexact.
    c = cyc;
    bus.start = 1'b1; bus.target = 16'd4; bus.increment = 16'd3;
    expect_ev(EV_DN,   c + 2,  16'd8, 1'b0, 1'b1);
    expect_ev(EV_DN,   c + 8,  16'd5, 1'b0, 1'b1);
    expect_ev(EV_DONE, c + 14, 16'd5, 1'b1, 1'b0);
    @(negedge clk_2M5);
    bus.start = 1'b0;
    drain(40);

    // load and start together, then start while busy: only the load happens.
    c = cyc;
    bus.load = 1'b1; bus.start = 1'b1; bus.preload = 16'd3;
    bus.target = 16'd9; bus.increment = 16'd1;
    expect_ev(EV_RST,  c + 1, 16'd3, 1'b1, 1'b1);
    expect_ev(EV_DONE, c + 5, 16'd3, 1'b1, 1'b1);
    @(negedge clk_2M5);
    bus.load = 1'b0;
    @(negedge clk_2M5);
    bus.start = 1'b0;
    drain(20);
    check("load_wins_model", bus.model_count, 16'd3);

    // Already on target: no pulses, exact.
    c = cyc;
    bus.start = 1'b1; bus.target = 16'd3; bus.increment = 16'd4;
    expect_ev(EV_DONE, c + 2, 16'd3, 1'b0, 1'b0);
    @(negedge clk_2M5);
    bus.start = 1'b0;
    drain(10);

    // Zero increment with a distant target: no pulses, inexact.
    c = cyc;
    bus.start = 1'b1; bus.target = 16'd8; bus.increment = 16'd0;
    expect_ev(EV_DONE, c + 2, 16'd3, 1'b1, 1'b0);
    @(negedge clk_2M5);
    bus.start = 1'b0;
    drain(10);

    // Near the top of the range: one big step, then stop short instead of wrapping.
    c = cyc;
    bus.start = 1'b1; bus.target = 16'hFFFF; bus.increment = 16'h8000;
    expect_ev(EV_UP,   c + 2, 16'h8003, 1'b0, 1'b1);
    expect_ev(EV_DONE, c + 8, 16'h8003, 1'b1, 1'b0);
    @(negedge clk_2M5);
    bus.start = 1'b0;
    drain(20);

    // Reset asserted during the second cycle of an up pulse.
    c = cyc;
    bus.start = 1'b1; bus.target = 16'h8005; bus.increment = 16'd1;
    expect_ev(EV_UP, c + 2, 16'h8004, 1'b0, 1'b1);
    @(negedge clk_2M5);
    bus.start = 1'b0;
    n = 0;
    while (cyc != c + 3 && n < 10) begin
      @(negedge clk_2M5);
      n++;
    end
    check("second_pulse_cycle_step_up", bus.step_up, 1);
    #50 reset = 1'b0;
    #1 check_all_low("mid_reset");
    repeat (2) @(negedge clk_2M5);
    reset = 1'b1;
    repeat (20) @(negedge clk_2M5);
    check("post_reset_busy",  bus.busy,        0);
    check("post_reset_model", bus.model_count, 0);
    check("post_reset_queue", exp_q.size(),    0);

    // Recovery with a fresh load.
    c = cyc;
    bus.load = 1'b1; bus.preload = 16'd7;
    expect_ev(EV_RST,  c + 1, 16'd7, 1'b0, 1'b1);
    expect_ev(EV_DONE, c + 5, 16'd7, 1'b0, 1'b1);
    @(negedge clk_2M5);
    bus.load = 1'b0;
    drain(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/step_pulse_driver.md
Name: step_pulse_driver

Overview:
- Initiator side of the up/down/reset pulse interface used by our preloadable up/down counters.
- Given a target value, emits clean, spaced step_up / step_dn / step_rst pulses on the clk_2M5 domain so that a downstream counter (which edge-detects and debounces its inputs with a two-flop sampler) moves from its current value to the target.
- Keeps an internal model of the downstream count so the host can command absolute positions instead of issuing individual steps.

Parameters:
- WIDTH, 16, width of count, target, preload and increment.
- PULSE_LEN, 2, clk_2M5 cycles each step pulse is held high (min 1).
- GAP_LEN, 3, clk_2M5 cycles forced low after each pulse (min 2, so the downstream two-flop sampler sees every edge).

Ports:
- clk_2M5  in  1  system clock (2.5 MHz).
- reset  in  1  asynchronous, active-low reset.
- load  in  1  one-cycle request: drive a step_rst pulse and set model to preload.
- start  in  1  one-cycle request: step the model toward target.
- preload  in  WIDTH  value the downstream counter takes on reset; sampled when load is accepted.
- target  in  WIDTH  destination value; sampled when start is accepted.
- increment  in  WIDTH  step size; sampled when start is accepted.
- step_up  out  1  up pulse to downstream clk_up.
- step_dn  out  1  down pulse to downstream clk_dn.
- step_rst  out  1  reset pulse to downstream reset.
- model_count  out  WIDTH  modelled downstream count.
- busy  out  1  high whenever the FSM is not IDLE.
- done  out  1  one-cycle pulse when a load or move completes.
- inexact  out  1  sticky until the next accepted start: the target could not be reached exactly.

Behaviour:
- Reset (async, reset=0): FSM=IDLE; all outputs 0; model_count=0; latched target and increment=0.
- Registered outputs throughout; no combinational path from inputs to outputs.
- States: IDLE, DECIDE, PULSE, GAP.
- IDLE transitions:
  - load=1: latch preload, assert step_rst, enter PULSE (kind=RST).
  - else start=1: latch target and increment, clear inexact, enter DECIDE.
  - load and start in the same cycle: load wins; start is dropped, not queued.
  - load/start while busy=1: ignored.
- DECIDE (one cycle): unsigned compare of model_count (m) and latched target (t), step i.
  - m==t: done=1, go IDLE.
  - i==0 and m!=t: inexact=1, done=1, go IDLE.
  - t>m: if (t-m)>=i, assert step_up and enter PULSE (kind=UP); else inexact=1, done=1, go IDLE.
  - t<m: if (m-t)>=i, assert step_dn and enter PULSE (kind=DN); else inexact=1, done=1, go IDLE.
  - Comparisons are on differences, so the model never wraps past 0 or 2^WIDTH-1.
- PULSE: exactly one of step_up/step_dn/step_rst is high for exactly PULSE_LEN cycles. Model updates on the first pulse cycle: UP m+i, DN m-i, RST m=preload latch. Then go GAP.
- GAP: all step outputs low for exactly GAP_LEN cycles.
  - Kind RST: done=1 on the last GAP cycle, then IDLE.
  - Kind UP/DN: return to DECIDE.
- Latency: start accepted at edge 0 -> DECIDE at edge 1 -> first pulse high from edge 2. Pulse period = PULSE_LEN+GAP_LEN+1 cycles.
- At most one step output is high in any cycle; outputs never glitch between states.
- Reset asserted mid-operation: outputs drop to 0 immediately (async). Any partial pulse is abandoned and the model is not rolled back; the host must issue load afterwards.

Test Plan:
- Reset then load with preload=5 -> step_rst high 2 cycles, low 3 cycles; model_count=5; single done pulse; busy high for 5 cycles.
- From model=5, start with target=11, increment=2 -> exactly 3 step_up pulses, 6-cycle spacing, first pulse 2 cycles after start; model_count 7, 9, 11; done=1; inexact=0.
- From model=11, start with target=4, increment=3 -> 2 step_dn pulses; model_count=5; done=1 and inexact=1; no third pulse.
- load and start asserted together, then start asserted while busy -> only step_rst occurs; both starts ignored; model_count=preload.
- target=model, or increment=0 with target!=model -> no pulses; done one cycle after DECIDE; inexact=0 and 1 respectively.
- Reset released to 0 during the second step_up cycle -> step_up drops immediately; all outputs 0; after release, no pulses until a new load or start.
